// File: rtl/sdram_init_checker_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_init_checker_if : SDRAM command bus taps plus checker verdict outputs
// Revision: 1.0
// ----------------------------------------------------------------------------
interface sdram_init_checker_if #(
  parameter int CNT_W = 16
);
  logic             chk_enable;
  logic             sdr_cs_n;
  logic             sdr_ras_n;
  logic             sdr_cas_n;
  logic             sdr_we_n;
  logic             sdr_init_done;
  logic             init_pass;
  logic             init_fail;
  logic [3:0]       err_code;
  logic [CNT_W-1:0] err_cycle;
  logic [3:0]       aref_count;
  logic [2:0]       chk_state;

  modport master (
    output chk_enable, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_init_done,
    input  init_pass, init_fail, err_code, err_cycle, aref_count, chk_state
  );

  modport slave (
    input  chk_enable, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_init_done,
    output init_pass, init_fail, err_code, err_cycle, aref_count, chk_state
  );
endinterface
`default_nettype wire

// File: rtl/sdram_init_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_init_checker : watches the SDRAM power-up sequence, reports first error
// Revision: 1.0
// ----------------------------------------------------------------------------
module sdram_init_checker #(
  parameter int T_PWRUP    = 500,
  parameter int T_RP       = 3,
  parameter int T_RFC      = 8,
  parameter int N_AREF     = 2,
  parameter int T_DONE_MAX = 16,
  parameter int T_TIMEOUT  = 2048,
  parameter int CNT_W      = 16
) (
  input  logic                sdram_clk,
  input  logic                sdram_resetn,
  sdram_init_checker_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PWRUP = 3'd1,
    S_TRP   = 3'd2,
    S_AREF  = 3'd3,
    S_MRD   = 3'd4,
    S_PASS  = 3'd5,
    S_FAIL  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_PRE  = 3'd1,
    CMD_AREF = 3'd2,
    CMD_LMR  = 3'd3,
    CMD_ILL  = 3'd4
  } cmd_e;

  localparam logic [3:0] E_NONE       = 4'd0;
  localparam logic [3:0] E_EARLY_CMD  = 4'd1;
  localparam logic [3:0] E_ORDER      = 4'd2;
  localparam logic [3:0] E_TRP        = 4'd3;
  localparam logic [3:0] E_TRFC       = 4'd4;
  localparam logic [3:0] E_NAREF      = 4'd5;
  localparam logic [3:0] E_DONE_TO    = 4'd6;
  localparam logic [3:0] E_EARLY_DONE = 4'd7;
  localparam logic [3:0] E_WDOG       = 4'd8;

  localparam logic [CNT_W-1:0] L_PWRUP    = CNT_W'(T_PWRUP);
  localparam logic [CNT_W-1:0] L_RP       = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] L_RFC      = CNT_W'(T_RFC);
  localparam logic [CNT_W-1:0] L_DONE_MAX = CNT_W'(T_DONE_MAX);
  localparam logic [CNT_W-1:0] L_TIMEOUT  = CNT_W'(T_TIMEOUT);
  localparam logic [3:0]       L_NAREF    = 4'(N_AREF);

  state_e           state_q;
  logic [CNT_W-1:0] stamp_q;
  logic [CNT_W-1:0] gap_q;
  logic [3:0]       aref_q;
  logic             pass_q;
  logic             fail_q;
  logic [3:0]       code_q;
  logic [CNT_W-1:0] cycle_q;

  cmd_e             cmd;
  logic [3:0]       err_d;
  logic [CNT_W-1:0] stamp_d;
  logic [CNT_W-1:0] gap_d;
  logic [3:0]       aref_d;
  logic             active;
  logic             pre_mrd;

  always_comb begin
    cmd = CMD_ILL;
    if (bus.sdr_cs_n) begin
      cmd = CMD_NOP;
    end else begin
      case ({bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n})
        3'b111:  cmd = CMD_NOP;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_AREF;
        3'b000:  cmd = CMD_LMR;
        default: cmd = CMD_ILL;
      endcase
    end
  end

  assign stamp_d = (&stamp_q) ? stamp_q : stamp_q + CNT_W'(1);
  assign gap_d   = (&gap_q)   ? gap_q   : gap_q + CNT_W'(1);
  assign aref_d  = (&aref_q)  ? aref_q  : aref_q + 4'd1;
  assign active  = (state_q inside {S_PWRUP, S_TRP, S_AREF, S_MRD});
  assign pre_mrd = (state_q inside {S_PWRUP, S_TRP, S_AREF});

  // Error priority: early init_done > command/timing error > watchdog.
  always_comb begin
    err_d = E_NONE;
    case (state_q)
      S_PWRUP: begin
        if (cmd != CMD_NOP) begin
          if (gap_q < L_PWRUP)     err_d = E_EARLY_CMD;
          else if (cmd != CMD_PRE) err_d = E_ORDER;
        end
      end
      S_TRP: begin
        if (cmd == CMD_AREF) begin
          if (gap_q < L_RP) err_d = E_TRP;
        end else if (cmd != CMD_NOP) begin
          err_d = E_ORDER;
        end
      end
      S_AREF: begin
        if (cmd == CMD_AREF || cmd == CMD_LMR) begin
          if (gap_q < L_RFC)                             err_d = E_TRFC;
          else if (cmd == CMD_LMR && aref_q < L_NAREF)   err_d = E_NAREF;
        end else if (cmd != CMD_NOP) begin
          err_d = E_ORDER;
        end
      end
      S_MRD: begin
        if (cmd != CMD_NOP)          err_d = E_ORDER;
        else if (gap_q > L_DONE_MAX) err_d = E_DONE_TO;
      end
      default: err_d = E_NONE;
    endcase
    if (pre_mrd && bus.sdr_init_done) err_d = E_EARLY_DONE;
    if (err_d == E_NONE && active && stamp_q >= L_TIMEOUT) err_d = E_WDOG;
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q <= S_IDLE;
      stamp_q <= '0;
      gap_q   <= '0;
      aref_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= E_NONE;
      cycle_q <= '0;
    end else if (!bus.chk_enable) begin
      state_q <= S_IDLE;
      stamp_q <= '0;
      gap_q   <= '0;
      aref_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= E_NONE;
      cycle_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_PWRUP;
          stamp_q <= '0;
          gap_q   <= '0;
          aref_q  <= '0;
        end
        S_PWRUP, S_TRP, S_AREF, S_MRD: begin
          stamp_q <= stamp_d;
          if (err_d != E_NONE) begin
            state_q <= S_FAIL;
            fail_q  <= 1'b1;
            code_q  <= err_d;
            cycle_q <= stamp_q;
          end else if (cmd != CMD_NOP) begin
            // Only the legal next command of the sequence reaches this branch.
            gap_q <= '0;
            case (state_q)
              S_PWRUP: state_q <= S_TRP;
              S_TRP: begin
                state_q <= S_AREF;
                aref_q  <= 4'd1;
              end
              default: begin
                if (cmd == CMD_LMR) state_q <= S_MRD;
                else                aref_q  <= aref_d;
              end
            endcase
          end else begin
            gap_q <= gap_d;
            if (state_q == S_MRD && bus.sdr_init_done) begin
              state_q <= S_PASS;
              pass_q  <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.init_pass  = pass_q;
  assign bus.init_fail  = fail_q;
  assign bus.err_code   = code_q;
  assign bus.err_cycle  = cycle_q;
  assign bus.aref_count = aref_q;
  assign bus.chk_state  = state_q;

endmodule
`default_nettype wire
